seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It holds a 16-bit display value and rotates one shared `hex_to_7seg_structural` decoder across the four digits, driving one active-low anode per time slot. New values arrive through a valid/ready handshake and are committed only at frame boundaries, so the display never tears. The block sits between the system datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/hex_to_7seg_structural.sv | 18 +
 rtl/seg7_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF,
    GUARD,
    DRIVE
  } seg7_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  // True when digit d and every digit above it hold zero; digit 0 never qualifies.
  function automatic logic lead_zero(input logic [15:0] value, input digit_idx_t d);
    logic [15:0] upper;
    upper = value >> {d, 2'b00};
    return (d != 2'd0) && (upper == 16'h0000);
  endfunction

endpackage

// File: rtl/hex_to_7seg_structural.sv
// Hex nibble to active-low segment pattern, ordered {g,f,e,d,c,b,a}.
module hex_to_7seg_structural (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  always_comb begin
    seg = GLYPH[hex];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode scan controller with frame-aligned
// value updates through a one-entry pending buffer.
module seg7_scan_ctrl #(
  parameter int unsigned DIV_CYCLES = 50_000,
  parameter int unsigned GUARD      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  import seg7_pkg::*;

  localparam int unsigned       CNT_W      = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(DIV_CYCLES - 1);
  localparam digit_idx_t        LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  seg7_state_t      state;
  logic [CNT_W-1:0] cnt;
  digit_idx_t       digit;
  logic [15:0]      shadow;
  logic [15:0]      pending;
  logic             pend_full;

  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             frame_end;
  logic             lit;

  always_comb begin
    nibble    = shadow[{digit, 2'b00} +: 4];
    frame_end = (state == seg7_pkg::OFF) ||
                ((state == seg7_pkg::DRIVE) && (digit == LAST_DIGIT) && (cnt == SLOT_LAST));
    lit       = (state == seg7_pkg::DRIVE) && !(blank_lz && lead_zero(shadow, digit));
  end

  hex_to_7seg_structural u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Scan FSM; outputs are registered from the current slot position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seg7_pkg::OFF;
      cnt   <= '0;
      digit <= '0;
      an    <= AN_OFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (lit) begin
        an  <= ~(4'b0001 << digit);
        seg <= dec_seg;
        dp  <= ~dp_mask[digit];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end

      if (!enable) begin
        state <= seg7_pkg::OFF;
        cnt   <= '0;
        digit <= '0;
      end else begin
        case (state)
          seg7_pkg::OFF: begin
            state <= seg7_pkg::GUARD;
            cnt   <= '0;
          end
          seg7_pkg::GUARD: begin
            cnt <= cnt + 1'b1;
            if (cnt == GUARD_LAST) state <= seg7_pkg::DRIVE;
          end
          seg7_pkg::DRIVE: begin
            if (cnt == SLOT_LAST) begin
              state <= seg7_pkg::GUARD;
              cnt   <= '0;
              digit <= digit + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= seg7_pkg::OFF;
        endcase
      end
    end
  end

  // A transfer needs pend_full, an accept needs it clear, so the two never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      pending    <= '0;
      pend_full  <= 1'b0;
      load_ready <= 1'b1;
    end else if (pend_full && frame_end) begin
      shadow     <= pending;
      pend_full  <= 1'b0;
      load_ready <= 1'b1;
    end else if (load_valid && load_ready) begin
      pending    <= load_data;
      pend_full  <= 1'b1;
      load_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: slot-position reference model plus table rows and
// hand-written sequences for handshake, enable and reset corners.
module tb_seg7_scan_ctrl;

  localparam int unsigned DIV   = 8;
  localparam int unsigned GRD   = 2;
  localparam int          FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIV_CYCLES(DIV), .GUARD(GRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Active-high lit-segment sets, bit 0 = a.
  logic [6:0] lit_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  bit          m_on;
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  bit          m_full;
  bit          accepted;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_ready;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    return ~lit_tab[h];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_shadow = '0; m_pend = '0; m_full = 0;
  endtask

  // One clock: predict outputs from the pre-edge slot position, advance, compare.
  task automatic step();
    int d;
    bit lit;
    bit boundary;
    @(posedge clk);
    d   = m_pos / DIV;
    lit = m_on && ((m_pos % DIV) >= GRD) &&
          !(blank_lz && d != 0 && ((m_shadow >> (4 * d)) == 16'h0));
    e_an  = lit ? ~(4'b0001 << d) : 4'hF;
    e_seg = lit ? glyph(m_shadow[4*d +: 4]) : 7'h7F;
    e_dp  = lit ? ~dp_mask[d] : 1'b1;
    boundary = !m_on || (m_pos == FRAME - 1);
    accepted = 0;
    if (m_full && boundary) begin
      m_shadow = m_pend;
      m_full   = 0;
    end else if (!m_full && load_valid) begin
      m_pend   = load_data;
      m_full   = 1;
      accepted = 1;
    end
    e_ready = !m_full;
    if (!enable) begin
      m_on = 0; m_pos = 0;
    end else if (!m_on) begin
      m_on = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("load_ready", load_ready, e_ready);
  endtask

  task automatic offer(input logic [15:0] v);
    bit got;
    got = 0;
    load_valid = 1'b1;
    load_data  = v;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      got = accepted;
    end
    load_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL offer_timeout: value %h not accepted within 200 cycles", v);
    end
  endtask

  task automatic wait_transfer();
    for (int i = 0; i < 200 && m_full; i++) step();
    vectors++;
    if (m_full) begin
      miscompares++;
      $display("FAIL transfer_timeout: pending value never reached the display");
    end
  endtask

  task automatic run_to(input int pos);
    bit hit;
    hit = m_on && m_pos == pos;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = m_on && m_pos == pos;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL run_to_timeout: slot position %0d not reached", pos);
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  dpm;
    int          pos;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t tab [12];
  int   low_cnt [4];

  initial begin
    tab[0]  = '{16'h1234, 1'b0, 4'b0000,  4, 4'b1110, 7'b0011001, 1'b1};
    tab[1]  = '{16'h1234, 1'b0, 4'b0000, 28, 4'b0111, 7'b1111001, 1'b1};
    tab[2]  = '{16'h1234, 1'b0, 4'b0000,  1, 4'b1111, 7'h7F,      1'b1};
    tab[3]  = '{16'h1234, 1'b0, 4'b0100, 20, 4'b1011, 7'b0100100, 1'b0};
    tab[4]  = '{16'h1234, 1'b0, 4'b0100, 12, 4'b1101, 7'b0110000, 1'b1};
    tab[5]  = '{16'hABCD, 1'b0, 4'b0000,  4, 4'b1110, 7'b0100001, 1'b1};
    tab[6]  = '{16'h0050, 1'b1, 4'b0000, 28, 4'b1111, 7'h7F,      1'b1};
    tab[7]  = '{16'h0050, 1'b1, 4'b0000, 20, 4'b1111, 7'h7F,      1'b1};
    tab[8]  = '{16'h0050, 1'b1, 4'b0000, 12, 4'b1101, 7'b0010010, 1'b1};
    tab[9]  = '{16'h0050, 1'b1, 4'b0000,  4, 4'b1110, 7'b1000000, 1'b1};
    tab[10] = '{16'h0000, 1'b1, 4'b0000, 12, 4'b1111, 7'h7F,      1'b1};
    tab[11] = '{16'h0000, 1'b1, 4'b0000,  4, 4'b1110, 7'b1000000, 1'b1};

    rst = 1'b1; enable = 1'b0; blank_lz = 1'b0; dp_mask = 4'b0000;
    load_valid = 1'b0; load_data = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_ready", load_ready, 1'b1);
    rst = 1'b0;
    enable = 1'b1;

    // Anode walk: six lit cycles per digit after two guard cycles.
    offer(16'h1234);
    wait_transfer();
    run_to(0);
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) low_cnt[k]++;
    end
    for (int k = 0; k < 4; k++) check("anode_low_cycles", 16'(low_cnt[k]), 16'd6);

    foreach (tab[r]) begin
      blank_lz = tab[r].blz;
      dp_mask  = tab[r].dpm;
      if (m_shadow != tab[r].value) begin
        offer(tab[r].value);
        wait_transfer();
      end
      run_to(tab[r].pos);
      step();
      check("tab_an", an, tab[r].an);
      check("tab_seg", seg, tab[r].seg);
      check("tab_dp", dp, tab[r].dp);
    end
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;

    // Back-to-back offers: the second stalls until the frame boundary.
    run_to(2);
    offer(16'hABCD);
    run_to(12);
    check("stall_ready_low", load_ready, 1'b0);
    offer(16'h0001);
    check("second_accept_pos", 16'(m_pos), 16'd1);
    wait_transfer();
    run_to(4);
    step();
    check("after_switch_seg", seg, 7'b1111001);

    // Enable falls at digit 1, cnt 5; re-enable restarts at digit 0 guard.
    run_to(13);
    enable = 1'b0;
    step();
    check("en_fall_still_lit", an, 4'b1101);
    step();
    check("en_fall_dark", an, 4'hF);
    repeat (3) step();
    enable = 1'b1;
    repeat (3) step();
    check("reenable_guard", an, 4'hF);
    step();
    check("reenable_digit0", an, 4'b1110);

    // Asynchronous reset in the middle of a DRIVE slot.
    offer(16'h5A5A);
    run_to(20);
    step();
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", an, 4'hF);
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_ready", load_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run_to(4);
    step();
    check("post_rst_cleared", seg, 7'b1000000);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (enable ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 3) == 0))
        enable = ~enable;
      if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 39) == 0) dp_mask = 4'($urandom_range(0, 15));
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
